memory_32_5_ram: RTL and testbench
==================================

Name: memory_32_5_ram

Overview:
- Simple dual-port synchronous RAM: 32 entries x 32 bits, one write port and one read port, both on the same clock.
- Used as the per-lane tap/coefficient store inside the neural-layer tap memory wrapper.
- Six instances are built side by side to form a 192-bit word.
- Contents can be preloaded at elaboration through a hierarchical $readmemh on the storage array.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; clock clk.
- m_rd_address  input  ADDR_W  read address.
- m_rd_vld  input  1  read enable.
- m_wr_address  input  ADDR_W  write address.
- m_wr_vld  input  1  write enable.
- m_wr_data  input  WIDTH  write data.
- m_rd_data  output  WIDTH  registered read data.

Behaviour:
- Storage: array of 2**ADDR_W words of WIDTH bits, named memory_32_5_memory. This name is fixed so that testbenches and wrappers can preload it hierarchically with $readmemh.
- Storage is never cleared by reset. Preloaded or previously written contents survive reset.
- Write:
  - On a rising edge with m_wr_vld=1, memory[m_wr_address] <= m_wr_data.
  - Writes are accepted during reset.
  - No write occurs when m_wr_vld=0.
- Read:
  - On a rising edge with m_rd_vld=1 and reset=0, m_rd_data <= memory[m_rd_address].
  - Latency is 1 cycle: the address is presented in cycle N and the data is valid after edge N, i.e. in cycle N+1.
- Read hold: when m_rd_vld=0, m_rd_data holds its last value.
- Reset:
  - Output: on a rising edge with reset=1, m_rd_data <= 0. Reset has priority over a concurrent read.
  - Reset mid-operation discards any read issued in the same cycle.
- Read-during-write, same address, same cycle: read-first. m_rd_data returns the old stored word; the new word is visible on the next read (unless the optional feature below is enabled).
- Simultaneous read and write to different addresses: fully independent.
- Addressing:
  - Addresses are unsigned and cover the full range 0..31; there are no out-of-range addresses.
  - An X or Z address must not corrupt other entries (simulation only).
- No handshake or back-pressure: every enabled access completes in one cycle.
- Unwritten, unloaded entries read as X in simulation; no defined value is required.

Optional Feature:
- Macro: MEMORY_32_5_RAM_BYPASS_EN.
- Defined (write-first): when m_rd_vld=1, m_wr_vld=1 and m_rd_address == m_wr_address in the same cycle, m_rd_data <= m_wr_data on that edge. Other behaviour is unchanged, and reset still has priority.
- Undefined: read-first behaviour as stated in Behaviour.

Test Plan:
- Reset/hold:
  - Assert reset for 2 cycles -> m_rd_data = 0x00000000.
  - Deassert reset, keep m_rd_vld=0 for 3 cycles -> m_rd_data stays 0.
- Write/readback:
  - Write 0xDEADBEEF to address 3 and 0x12345678 to address 31 on consecutive cycles.
  - Read address 3 -> 0xDEADBEEF one cycle later.
  - Read address 31 -> 0x12345678 one cycle later.
- Preload and reset persistence:
  - $readmemh-load the array with value = index (entry k = k), then read addresses 0..31 back-to-back -> data k appears in cycle k+1, giving full-rate throughput.
  - Pulse reset -> m_rd_data = 0.
  - Read address 7 -> 0x00000007 (contents preserved).
- Collision:
  - Address 5 holds 0xAAAA0000; in one cycle write 0x5555FFFF to address 5 and read address 5.
  - Without the macro -> 0xAAAA0000. With MEMORY_32_5_RAM_BYPASS_EN -> 0x5555FFFF.
  - A follow-up read of address 5 -> 0x5555FFFF in both builds.
- Independent ports: write address 10 while reading address 20 (holding 0x11111111) in the same cycle -> read returns 0x11111111 and address 10 is updated.
- Reset vs read: issue a read of address 31 while reset=1 -> m_rd_data = 0 (not 0x12345678). A write issued in that same cycle still lands.

Source files
------------

// File: rtl/memory_32_5_ram.sv
// Simple dual-port 32x32 RAM, one write and one registered read port.
// Optional write-first bypass: define MEMORY_32_5_RAM_BYPASS_EN.
module memory_32_5_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m_rd_address,
  input  logic              m_rd_vld,
  input  logic [ADDR_W-1:0] m_wr_address,
  input  logic              m_wr_vld,
  input  logic [WIDTH-1:0]  m_wr_data,
  output logic [WIDTH-1:0]  m_rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Name is fixed: wrappers preload it hierarchically.
  logic [WIDTH-1:0] memory_32_5_memory [DEPTH];

  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Next read data: hold, read-first lookup, or bypassed write data.
  always_comb begin
    rd_data_d = rd_data_q;
    if (m_rd_vld) begin
      rd_data_d = memory_32_5_memory[m_rd_address];
`ifdef MEMORY_32_5_RAM_BYPASS_EN
      if (m_wr_vld && (m_wr_address == m_rd_address)) begin
        rd_data_d = m_wr_data;
      end
`endif
    end
  end

  // Write port; storage is never cleared and writes land during reset.
  always_ff @(posedge clk) begin
    if (m_wr_vld) begin
      memory_32_5_memory[m_wr_address] <= m_wr_data;
    end
  end

  // Read register; reset wins over a concurrent read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign m_rd_data = rd_data_q;

endmodule

// File: tb/tb_memory_32_5_ram.sv
// Directed bench for memory_32_5_ram.
// Vector table plus hand sequences for fill/readback and reset persistence.
module tb_memory_32_5_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  m_rd_address;
  logic        m_rd_vld;
  logic [4:0]  m_wr_address;
  logic        m_wr_vld;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data;

  int checks = 0;
  int errors = 0;

`ifdef MEMORY_32_5_RAM_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h5555FFFF;
`else
  localparam logic [31:0] COLL_EXP = 32'hAAAA0000;
`endif

  memory_32_5_ram #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_rd_address (m_rd_address),
    .m_rd_vld     (m_rd_vld),
    .m_wr_address (m_wr_address),
    .m_wr_vld     (m_wr_vld),
    .m_wr_data    (m_wr_data),
    .m_rd_data    (m_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        rvld;
    logic [4:0]  ra;
    logic        wvld;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic rst,
                     input logic rvld, input logic [4:0] ra,
                     input logic wvld, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.name = n; v.rst = rst; v.rvld = rvld; v.ra = ra;
    v.wvld = wvld; v.wa = wa; v.wd = wd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic rvld,
                       input logic [4:0] ra, input logic wvld,
                       input logic [4:0] wa, input logic [31:0] wd);
    reset = rst; m_rd_vld = rvld; m_rd_address = ra;
    m_wr_vld = wvld; m_wr_address = wa; m_wr_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [31:0] exp);
    checks++;
    if (m_rd_data !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, m_rd_data, exp);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

    add("rst0",      1, 0, 0,  0, 0,  32'h0,        32'h0);
    add("rst1",      1, 0, 0,  0, 0,  32'h0,        32'h0);
    add("idle0",     0, 0, 0,  0, 0,  32'h0,        32'h0);
    add("idle1",     0, 0, 0,  0, 0,  32'h0,        32'h0);
    add("idle2",     0, 0, 0,  0, 0,  32'h0,        32'h0);
    add("wr3",       0, 0, 0,  1, 3,  32'hDEADBEEF, 32'h0);
    add("wr31",      0, 0, 0,  1, 31, 32'h12345678, 32'h0);
    add("rd3",       0, 1, 3,  0, 0,  32'h0,        32'hDEADBEEF);
    add("rd31",      0, 1, 31, 0, 0,  32'h0,        32'h12345678);
    add("nowr_hold", 0, 0, 0,  0, 3,  32'hFFFFFFFF, 32'h12345678);
    add("nowr_rd3",  0, 1, 3,  0, 0,  32'h0,        32'hDEADBEEF);
    add("wr5",       0, 0, 0,  1, 5,  32'hAAAA0000, 32'hDEADBEEF);
    add("wr20",      0, 0, 0,  1, 20, 32'h11111111, 32'hDEADBEEF);
    add("collide",   0, 1, 5,  1, 5,  32'h5555FFFF, COLL_EXP);
    add("rd5_after", 0, 1, 5,  0, 0,  32'h0,        32'h5555FFFF);
    add("indep",     0, 1, 20, 1, 10, 32'hCAFEF00D, 32'h11111111);
    add("rd10",      0, 1, 10, 0, 0,  32'h0,        32'hCAFEF00D);
    add("rst_vs_rd", 1, 1, 31, 1, 31, 32'h0BADC0DE, 32'h0);
    add("rd31_new",  0, 1, 31, 0, 0,  32'h0,        32'h0BADC0DE);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rvld, vecs[i].ra,
            vecs[i].wvld, vecs[i].wa, vecs[i].wd);
      tick();
      check(vecs[i].name, vecs[i].exp);
    end

    // Fill entry k with k through the write port.
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b1, 5'(k), 32'(k));
      tick();
    end
    check("fill_hold", 32'h0BADC0DE);

    // Back-to-back reads at full rate.
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b1, 5'(k), 1'b0, 5'd0, 32'h0);
      tick();
      check($sformatf("stream%0d", k), 32'(k));
    end

    // Reset clears output but not storage.
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    tick();
    check("pulse_rst", 32'h0);
    drive(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    tick();
    check("persist7", 32'h7);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    tick();
    check("persist_hold", 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
